// File: rtl/exe_stage.sv
// exe_stage: pipeline execute stage.
//   Operand forwarding muxes, single-cycle ALU, branch resolution and an
//   iterative shift-add / restoring-divide unit that freezes the front end
//   through exe_stall while it runs.
// Build option: define EXE_FORWARD_EN to enable the forwarding muxes; when it
//   is undefined the operands come straight from the ID/EX register and the
//   fwd_sel*/mem_fwd_val/wb_fwd_val inputs are ignored.
// Ports:
//   clk, rst (async, active-low), flush   - clock, reset, mul/div abort
//   val1_in, val2_in, reg2_in, PC_in       - ID/EX operands, store data, PC+4
//   Br_type_in, exe_cmd_in                 - branch type, ALU opcode
//   fwd_sel1, fwd_sel2, fwd_sel_st         - forwarding selects
//   mem_fwd_val, wb_fwd_val                - forwarded values
//   alu_result, st_val                     - ALU/mul-div result, store data
//   br_taken, br_addr                      - branch decision and target
//   exe_stall                              - freeze IF/ID/IDEX, bubble EX/MEM
module exe_stage #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MD_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] val1_in,
    input  logic [WIDTH-1:0] val2_in,
    input  logic [WIDTH-1:0] reg2_in,
    input  logic [WIDTH-1:0] PC_in,
    input  logic [1:0]       Br_type_in,
    input  logic [3:0]       exe_cmd_in,
    input  logic [1:0]       fwd_sel1,
    input  logic [1:0]       fwd_sel2,
    input  logic [1:0]       fwd_sel_st,
    input  logic [WIDTH-1:0] mem_fwd_val,
    input  logic [WIDTH-1:0] wb_fwd_val,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] st_val,
    output logic             br_taken,
    output logic [WIDTH-1:0] br_addr,
    output logic             exe_stall
);

    localparam int unsigned SH_W  = $clog2(WIDTH);
    localparam int unsigned CNT_W = $clog2(MD_CYCLES);

    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0100;
    localparam logic [3:0] CMD_OR  = 4'b0101;
    localparam logic [3:0] CMD_NOR = 4'b0110;
    localparam logic [3:0] CMD_XOR = 4'b0111;
    localparam logic [3:0] CMD_SLL = 4'b1000;
    localparam logic [3:0] CMD_SRA = 4'b1001;
    localparam logic [3:0] CMD_SRL = 4'b1010;
    localparam logic [3:0] CMD_MUL = 4'b1100;
    localparam logic [3:0] CMD_DIV = 4'b1101;

    localparam logic [1:0] BR_BEZ = 2'b01;
    localparam logic [1:0] BR_BNE = 2'b10;
    localparam logic [1:0] BR_JMP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;        // multiplicand (MUL) / dividend-quotient shifter (DIV)
    logic [WIDTH-1:0]   r_b;        // multiplier (MUL) / divisor (DIV)
    logic [WIDTH-1:0]   r_acc;      // product (MUL) / partial remainder (DIV)
    logic [WIDTH-1:0]   r_result;
    logic               r_op_div;
    logic               r_neg;

    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_alu;
    logic               w_is_md;
    logic               w_start;
    logic               w_br_cond;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_a_nxt;
    logic [WIDTH-1:0]   w_b_nxt;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_md_raw;
    logic [WIDTH-1:0]   w_md_final;

    // Operand selection
`ifdef EXE_FORWARD_EN
    function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0] sel,
                                                 input logic [WIDTH-1:0] id_val,
                                                 input logic [WIDTH-1:0] mem_val,
                                                 input logic [WIDTH-1:0] wb_val);
        case (sel)
            2'b01:   return mem_val;
            2'b10:   return wb_val;
            default: return id_val;
        endcase
    endfunction

    assign w_a    = fwd_mux(fwd_sel1,   val1_in, mem_fwd_val, wb_fwd_val);
    assign w_b    = fwd_mux(fwd_sel2,   val2_in, mem_fwd_val, wb_fwd_val);
    assign st_val = fwd_mux(fwd_sel_st, reg2_in, mem_fwd_val, wb_fwd_val);
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{fwd_sel1, fwd_sel2, fwd_sel_st, mem_fwd_val, wb_fwd_val};

    assign w_a    = val1_in;
    assign w_b    = val2_in;
    assign st_val = reg2_in;
`endif

    // Single-cycle ALU; mul/div opcodes contribute 0 here
    always_comb begin
        w_alu = '0;
        case (exe_cmd_in)
            CMD_ADD: w_alu = w_a + w_b;
            CMD_SUB: w_alu = w_a - w_b;
            CMD_AND: w_alu = w_a & w_b;
            CMD_OR:  w_alu = w_a | w_b;
            CMD_NOR: w_alu = ~(w_a | w_b);
            CMD_XOR: w_alu = w_a ^ w_b;
            CMD_SLL: w_alu = w_a << w_b[SH_W-1:0];
            CMD_SRA: w_alu = WIDTH'($signed(w_a) >>> w_b[SH_W-1:0]);
            CMD_SRL: w_alu = w_a >> w_b[SH_W-1:0];
            default: w_alu = '0;
        endcase
    end

    assign w_is_md = (exe_cmd_in == CMD_MUL) || (exe_cmd_in == CMD_DIV);
    // rst gates the start so exe_stall stays low throughout reset
    assign w_start   = rst && !flush && w_is_md && (r_state == ST_IDLE);
    assign exe_stall = w_start || (r_state == ST_BUSY);

    assign alu_result = (r_state == ST_DONE) ? r_result : w_alu;

    // Branch resolution
    assign br_addr = PC_in + (w_b << 2);

    always_comb begin
        w_br_cond = 1'b0;
        case (Br_type_in)
            BR_BEZ:  w_br_cond = (w_a == '0);
            BR_BNE:  w_br_cond = (w_a != st_val);
            BR_JMP:  w_br_cond = 1'b1;
            default: w_br_cond = 1'b0;
        endcase
    end

    assign br_taken = w_br_cond && !exe_stall;

    // Magnitudes latched at start; sign applied once at the end
    assign w_abs_a = w_a[WIDTH-1] ? (~w_a + WIDTH'(1)) : w_a;
    assign w_abs_b = w_b[WIDTH-1] ? (~w_b + WIDTH'(1)) : w_b;

    // One mul/div iteration
    assign w_rem_sh = {r_acc, r_a[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_b};

    always_comb begin
        w_a_nxt   = r_a;
        w_b_nxt   = r_b;
        w_acc_nxt = r_acc;
        if (r_op_div) begin
            if (!w_diff[WIDTH]) begin
                w_acc_nxt = w_diff[WIDTH-1:0];
                w_a_nxt   = {r_a[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = w_rem_sh[WIDTH-1:0];
                w_a_nxt   = {r_a[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_nxt = r_b[0] ? (r_acc + r_a) : r_acc;
            w_a_nxt   = r_a << 1;
            w_b_nxt   = r_b >> 1;
        end
    end

    // Divide by zero returns all ones regardless of operand signs
    assign w_md_raw   = r_op_div ? w_a_nxt : w_acc_nxt;
    assign w_md_final = (r_op_div && (r_b == '0)) ? '1 :
                        (r_neg ? (~w_md_raw + WIDTH'(1)) : w_md_raw);

    // Mul/div sequencer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_op_div <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state  <= ST_BUSY;
                        r_cnt    <= '0;
                        r_a      <= w_abs_a;
                        r_b      <= w_abs_b;
                        r_acc    <= '0;
                        r_op_div <= exe_cmd_in[0];
                        r_neg    <= w_a[WIDTH-1] ^ w_b[WIDTH-1];
                    end
                end
                ST_BUSY: begin
                    if (flush) begin
                        r_state  <= ST_IDLE;
                        r_cnt    <= '0;
                        r_result <= '0;
                    end else begin
                        r_a   <= w_a_nxt;
                        r_b   <= w_b_nxt;
                        r_acc <= w_acc_nxt;
                        if (r_cnt == CNT_W'(MD_CYCLES - 1)) begin
                            r_state  <= ST_DONE;
                            r_cnt    <= '0;
                            r_result <= w_md_final;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (flush) begin
                        r_cnt    <= '0;
                        r_result <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage directly downstream of the ID/EX pipeline register; consumes its dst/val1/val2/reg2/PC/Br_type/exe_cmd/mem/wb/src fields.
- Contains:
  - forwarding muxes
  - single-cycle ALU
  - branch resolution
  - iterative 32-cycle multiply/divide unit that stalls the front end through exe_stall.
- Outputs feed the EX/MEM pipeline register and the IF-stage branch logic.

Parameters:
- WIDTH, 32, datapath width
- MD_CYCLES, 32, iterations of the mul/div engine; must equal WIDTH

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  aborts any in-flight mul/div and returns FSM to IDLE
- val1_in  in  32  operand 1 from ID/EX register
- val2_in  in  32  operand 2 (register or sign-extended immediate)
- reg2_in  in  32  store data
- PC_in  in  32  PC+4 of the instruction
- Br_type_in  in  2  00 none, 01 BEZ, 10 BNE, 11 JMP
- exe_cmd_in  in  4  ALU opcode
- fwd_sel1, fwd_sel2, fwd_sel_st  in  2 each  00 ID/EX value, 01 mem_fwd_val, 10 wb_fwd_val, 11 ID/EX value
- mem_fwd_val  in  32  ALU result held in EX/MEM register
- wb_fwd_val  in  32  write-back value
- alu_result  out  32  ALU or mul/div result
- st_val  out  32  forwarded store data
- br_taken  out  1  branch/jump taken
- br_addr  out  32  branch target
- exe_stall  out  1  freeze IF, ID and the ID/EX register; insert bubble into EX/MEM

Behaviour:
- Operand A is the fwd_sel1 mux of val1_in; operand B is the fwd_sel2 mux of val2_in; st_val is the fwd_sel_st mux of reg2_in.
- exe_cmd encoding:
  - 0000 ADD; 0010 SUB; 0100 AND; 0101 OR; 0110 NOR; 0111 XOR
  - 1000 SLL by B[4:0]; 1001 SRA; 1010 SRL
  - 1100 MUL (low 32 bits of signed product); 1101 DIV (signed quotient, truncation toward zero)
  - all others give 0.
- Add/sub wrap modulo 2^32; no overflow flag.
- Branches:
  - br_addr = PC_in + (val2_in << 2), wrapping.
  - br_taken: BEZ when A==0; BNE when A != st_val; JMP always; 00 never.
  - br_taken is forced to 0 while exe_stall=1.
- Mul/div FSM states: IDLE, BUSY, DONE.
  - IDLE: cmd 1100/1101 with flush=0 → exe_stall=1 combinationally; latch |A|, |B|, signs, op; counter=0; go BUSY.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIV) step per cycle; exe_stall=1; counter increments; after MD_CYCLES steps go DONE.
  - DONE: sign-corrected result in a 32-bit result register; alu_result = that register; exe_stall=0; next state IDLE unconditionally, even if the same opcode is still present.
  - Occupancy: 34 cycles in EX; exe_stall high for 33 consecutive cycles.
- Divide by zero: quotient 32'hFFFFFFFF regardless of sign; same latency. DIV of 0x80000000 by -1 gives 0x80000000.
- flush in BUSY or DONE: next state IDLE, counter and result register cleared; exe_stall drops the cycle after flush is sampled. flush in IDLE blocks a start that cycle.
- Combinational ALU ops never stall; alu_result is valid the same cycle.
- Reset (rst=0, asynchronous): FSM=IDLE, counter=0, result and operand registers=0, exe_stall=0. Combinational outputs follow inputs; br_taken is valid once rst=1. Reset mid-BUSY discards the operation.

Optional Feature:
- Macro: EXE_FORWARD_EN.
- Defined: forwarding muxes as above.
- Undefined:
  - fwd_sel1, fwd_sel2 and fwd_sel_st are ignored.
  - A=val1_in, B=val2_in, st_val=reg2_in.
  - mem_fwd_val and wb_fwd_val are unused.
  - All other behaviour is unchanged.

Test Plan:
- ALU ops:
  - ADD A=0x7FFFFFFF, B=1 → 0x80000000
  - SUB A=0, B=1 → 0xFFFFFFFF
  - SRA A=0x80000000, B=4 → 0xF8000000
  - NOR A=0, B=0 → 0xFFFFFFFF
  - All with exe_stall=0.
- Branch: BNE, PC_in=0x100, val2=3, A=5, st_val=6 → br_taken=1, br_addr=0x10C. Same case with A=6 → br_taken=0.
- Forwarding (EXE_FORWARD_EN defined): fwd_sel1=01, mem_fwd_val=10, val1_in=99, ADD B=5 → alu_result=15. fwd_sel1=10, wb_fwd_val=20 → 25.
- MUL A=-7, B=6:
  - exe_stall high exactly 33 cycles.
  - Next cycle alu_result=0xFFFFFFD6 with exe_stall=0.
  - Following cycle FSM back in IDLE.
- DIV:
  - A=-7, B=2 → 0xFFFFFFFD after 34-cycle occupancy.
  - A=5, B=0 → 0xFFFFFFFF.
- Abort:
  - flush asserted at BUSY cycle 10 → exe_stall 0 on the next cycle, result register 0.
  - rst low mid-BUSY → exe_stall 0 immediately, FSM IDLE after release.
